descrambler: RTL and testbench
==============================

DESCRAMBLER -- requirements
Module: descrambler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, giving the block width in bits; only 64 is supported and any other value SHALL be rejected at elaboration.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port data_in, input, DATA_WIDTH bits: scrambled 64b/66b payload; bit 0 is the first bit on the line.
REQ-005 SHALL have port data_in_valid, input, 1 bit: data_in is sampled only on cycles where this is high.
REQ-006 SHALL have port data_out, output, DATA_WIDTH bits: registered descrambled payload.
REQ-007 SHALL have port data_out_valid, output, 1 bit: high for exactly one cycle per accepted input word.

Function
REQ-008 SHALL implement the self-synchronizing descrambler for G(x) = 1 + x^39 + x^58 (IEEE 802.3 clause 49).
REQ-009 SHALL hold a 58-bit state register S holding the last 58 received scrambled bits; S[57] is the most recent bit.
REQ-010 For bit i = 0..63, define the serial history x[k] = data_in[k] for k >= 0, and x[k] = S[58+k] for k < 0.
REQ-011 The descrambled bit SHALL be out[i] = data_in[i] XOR x[i-39] XOR x[i-58], computed for all 64 bits in one cycle with no internal serial loop.
REQ-012 On a rising edge with data_in_valid=1: data_out SHALL take the value out[63:0], S SHALL take data_in[63:6], and data_out_valid SHALL be 1.
REQ-013 Latency SHALL be exactly 1 clock from the sampling edge to data_out.
REQ-014 On a rising edge with data_in_valid=0: S and data_out SHALL hold their values and data_out_valid SHALL be 0.
REQ-015 Gaps in data_in_valid SHALL NOT break descrambler continuity; back-to-back valid words SHALL be processed one per clock with no stall.
REQ-016 The block SHALL have no back-pressure input; data_out_valid is advisory and the downstream consumer must accept it.

Reset
REQ-017 While rst=1, S, data_out and data_out_valid SHALL be cleared to 0 asynchronously, including when rst asserts mid-stream.
REQ-018 The first valid word after reset SHALL be descrambled against an all-zero history.
REQ-019 The block SHALL self-synchronize, producing correct output from the 2nd word onward regardless of reset state.
REQ-020 When rst deasserts, the block SHALL be able to sample data_in on the first rising edge after deassertion.

Configuration
REQ-021 Macro DESCRAMBLER_BYPASS_EN, when defined, SHALL add a 1-bit input port bypass.
REQ-022 With DESCRAMBLER_BYPASS_EN defined and bypass=1, data_out SHALL take data_in unchanged with the same 1-cycle latency, and S SHALL still update so that deasserting bypass needs no resync.
REQ-023 With DESCRAMBLER_BYPASS_EN undefined, the bypass port and its logic SHALL be absent and the block SHALL always descramble.

Verification
REQ-024 Reset, then one valid word 64'h0000_0000_0000_0001 -> next cycle data_out=64'h0400_0080_0000_0001 and data_out_valid=1.
REQ-025 After reset, valid 64'h8000_0000_0000_0000 then valid 64'h0 -> data_out=64'h8000_0000_0000_0000, then 64'h0200_0040_0000_0000.
REQ-026 Drive a scrambler model output of 64'h7b2aaad555555555, 64'h46ff004433221100, 64'h5e8644a8b2070707 back-to-back -> from the 2nd word onward, output equals the original plaintext with valid high each cycle.
REQ-027 Valid word, 3 idle cycles with data_in changing, then valid word -> data_out and S are unchanged during the gap, data_out_valid=0 during the gap, and the second result equals the gapless result.
REQ-028 Assert rst between clock edges mid-stream -> data_out=0 and data_out_valid=0 immediately without a clock edge; the next word is descrambled with zero history.
REQ-029 With DESCRAMBLER_BYPASS_EN defined and bypass=1, input 64'hDEAD_BEEF_0123_4567 -> data_out=64'hDEAD_BEEF_0123_4567 one cycle later.

Source files
------------

// File: rtl/descrambler.sv
// Parallel 64b/66b self-synchronizing descrambler, G(x) = 1 + x^39 + x^58.
// Optional macro DESCRAMBLER_BYPASS_EN adds a bypass input that passes data_in through unchanged.
module descrambler #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DESCRAMBLER_BYPASS_EN
    input  logic                  bypass,
`endif
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid
);

    localparam int unsigned STATE_W = 58;
    localparam int unsigned TAP_A   = 39;

    generate
        if (DATA_WIDTH != 64) begin : g_bad_width
            $error("descrambler: DATA_WIDTH must be 64");
        end
    endgenerate

    logic [STATE_W-1:0]            s_q, s_d;
    logic [DATA_WIDTH-1:0]         data_out_q, data_out_d;
    logic                          data_out_valid_q, data_out_valid_d;
    logic [DATA_WIDTH+STATE_W-1:0] hist;
    logic [DATA_WIDTH-1:0]         descr;
    logic                          pass_through;

`ifdef DESCRAMBLER_BYPASS_EN
    assign pass_through = bypass;
`else
    assign pass_through = 1'b0;
`endif

    // hist[58+k] is serial bit x[k]: taps x[i-39] and x[i-58] become fixed slices.
    always_comb begin
        hist  = {data_in, s_q};
        descr = data_in
              ^ hist[DATA_WIDTH+STATE_W-TAP_A-1:STATE_W-TAP_A]
              ^ hist[DATA_WIDTH-1:0];

        s_d              = s_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        if (data_in_valid) begin
            s_d              = data_in[DATA_WIDTH-1:DATA_WIDTH-STATE_W];
            data_out_d       = pass_through ? data_in : descr;
            data_out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q              <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            s_q              <= s_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;

endmodule

// File: tb/tb_descrambler.sv
// Self-checking bench for descrambler: constant vector table, hand sequences,
// and randomized scrambled traffic against a serial bit-level reference model.
module tb_descrambler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [63:0] data_out;
    logic        data_out_valid;
`ifdef DESCRAMBLER_BYPASS_EN
    logic        bypass = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [57:0] mh;   // reference descrambler history, bit 57 most recent
    logic [57:0] sh;   // reference scrambler history

    descrambler #(.DATA_WIDTH(64)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef DESCRAMBLER_BYPASS_EN
        .bypass        (bypass),
`endif
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_out      (data_out),
        .data_out_valid(data_out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic [63:0] din;
        logic        vld;
        logic [63:0] exp_out;
        logic        exp_vld;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial walk through the line bits, one at a time, as the standard describes.
    function automatic logic [63:0] ref_descramble(input logic [63:0] d, input logic [57:0] h_in,
                                                   output logic [57:0] h_out);
        logic [57:0] h;
        logic [63:0] o;
        h = h_in;
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ h[19] ^ h[0];
            h    = {d[i], h[57:1]};
        end
        h_out = h;
        return o;
    endfunction

    function automatic logic [63:0] ref_scramble(input logic [63:0] p, input logic [57:0] h_in,
                                                 output logic [57:0] h_out);
        logic [57:0] h;
        logic [63:0] o;
        h = h_in;
        for (int i = 0; i < 64; i++) begin
            o[i] = p[i] ^ h[19] ^ h[0];
            h    = {o[i], h[57:1]};
        end
        h_out = h;
        return o;
    endfunction

    // Assert reset between edges, check async clear, release before the next edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_data_out", data_out, 64'h0);
        chk("rst_valid", {63'h0, data_out_valid}, 64'h0);
        #2 rst = 1'b0;
        mh = '0;
    endtask

    // Apply one word, advance one edge, compare against the reference model.
    task automatic apply_model(input string name, input logic [63:0] d, input logic v,
                               inout logic [63:0] exp_out);
        logic [57:0] hn;
        data_in       = d;
        data_in_valid = v;
        tick();
        if (v) begin
            exp_out = ref_descramble(d, mh, hn);
            mh      = hn;
        end
        chk({name, "_out"}, data_out, exp_out);
        chk({name, "_vld"}, {63'h0, data_out_valid}, {63'h0, v});
        data_in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_out;
        logic [63:0] p;
        logic [63:0] s;
        logic        v;
        logic [57:0] hn;
        int          words;

        vecs[0] = '{1'b1, 64'h0000_0000_0000_0001, 1'b1, 64'h0400_0080_0000_0001, 1'b1};
        vecs[1] = '{1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
        vecs[2] = '{1'b0, 64'h0000_0000_0000_0000, 1'b1, 64'h0200_0040_0000_0000, 1'b1};
        vecs[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0200_0040_0000_0000, 1'b0};
        vecs[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFC00_007F_FFFF_FFFF, 1'b1};
        vecs[5] = '{1'b1, 64'h0000_0000_0000_0001, 1'b1, 64'h0400_0080_0000_0001, 1'b1};
        vecs[6] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0400_0080_0000_0001, 1'b0};

        mh = '0;
        tick();
        chk("init_rst_out", data_out, 64'h0);
        chk("init_rst_vld", {63'h0, data_out_valid}, 64'h0);
        #2 rst = 1'b0;

        // Constant vectors, including a history-clearing mid-stream reset.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_rst) do_reset();
            data_in       = vecs[i].din;
            data_in_valid = vecs[i].vld;
            tick();
            chk($sformatf("vec%0d_out", i), data_out, vecs[i].exp_out);
            chk($sformatf("vec%0d_vld", i), {63'h0, data_out_valid}, {63'h0, vecs[i].exp_vld});
            data_in_valid = 1'b0;
        end

        // Known scrambler output words, back to back.
        do_reset();
        exp_out = '0;
        apply_model("kw0", 64'h7b2aaad555555555, 1'b1, exp_out);
        apply_model("kw1", 64'h46ff004433221100, 1'b1, exp_out);
        apply_model("kw2", 64'h5e8644a8b2070707, 1'b1, exp_out);

        // Gap of three idle cycles with changing data must not disturb continuity.
        do_reset();
        exp_out = '0;
        apply_model("gap_a", {$urandom, $urandom}, 1'b1, exp_out);
        for (int g = 0; g < 3; g++)
            apply_model($sformatf("gap_idle%0d", g), {$urandom, $urandom}, 1'b0, exp_out);
        apply_model("gap_b", {$urandom, $urandom}, 1'b1, exp_out);
        apply_model("gap_c", {$urandom, $urandom}, 1'b1, exp_out);

`ifdef DESCRAMBLER_BYPASS_EN
        bypass        = 1'b1;
        data_in       = 64'hDEAD_BEEF_0123_4567;
        data_in_valid = 1'b1;
        tick();
        exp_out = ref_descramble(64'hDEAD_BEEF_0123_4567, mh, hn);
        mh      = hn;
        chk("bypass_out", data_out, 64'hDEAD_BEEF_0123_4567);
        data_in_valid = 1'b0;
        bypass        = 1'b0;
        exp_out       = 64'hDEAD_BEEF_0123_4567;
        apply_model("post_bypass", {$urandom, $urandom}, 1'b1, exp_out);
`endif

        // Random plaintext through a scrambler with arbitrary start state.
        do_reset();
        exp_out = '0;
        sh      = {$urandom, $urandom};
        words   = 0;
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0);
            p = {$urandom, $urandom};
            if (v) begin
                s  = ref_scramble(p, sh, hn);
                sh = hn;
            end else begin
                s = {$urandom, $urandom};
            end
            apply_model($sformatf("rnd%0d", n), s, v, exp_out);
            if (v) begin
                if (words > 0) chk($sformatf("rnd%0d_plain", n), data_out, p);
                words++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
